// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - shared MDU op types for the EX stage
package ysyx_24080006_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ALU_MULL = 2'd0,
    ALU_MULH = 2'd1,
    ALU_DIV  = 2'd2,
    ALU_REM  = 2'd3
  } mdu_op_t;

  typedef struct packed {
    mdu_op_t op;
    logic    signed_a;
    logic    signed_b;
  } mdu_set_t;

endpackage

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// rtl/ysyx_24080006_mdu_ctrl.sv - issue/retire controller for the multi-cycle MDU
module ysyx_24080006_mdu_ctrl
  import ysyx_24080006_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  mdu_set_t        in_set,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  output mdu_set_t        mdu_set,
  output logic            mdu_valid,
  input  logic [XLEN-1:0] mdu_o,
  input  logic            mdu_ready,
  output logic            adder_sel_mdu,
  output logic            busy
);

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_RUN   = 2'd1,
    MC_DRAIN = 2'd2,
    MC_HOLD  = 2'd3
  } mc_state_t;

  mc_state_t       state;
  mc_state_t       state_nxt;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] res_q;
  mdu_set_t        op_set;
  logic            accept;
  logic            capture;

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    mdu_valid     = 1'b0;
    adder_sel_mdu = 1'b0;
    capture       = 1'b0;
    unique case (state)
      MC_IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) state_nxt = MC_RUN;
      end
      MC_RUN: begin
        mdu_valid     = 1'b1;
        adder_sel_mdu = 1'b1;
        if (mdu_ready) begin
          capture   = !flush;
          state_nxt = flush ? MC_IDLE : MC_HOLD;
        end else if (flush) begin
          state_nxt = MC_DRAIN;
        end
      end
      MC_DRAIN: begin
        // The MDU cannot abort, so keep it enabled until it finishes.
        mdu_valid     = 1'b1;
        adder_sel_mdu = 1'b1;
        if (mdu_ready) state_nxt = MC_IDLE;
      end
      MC_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !flush;
        if (flush) state_nxt = MC_IDLE;
        else if (out_ready) state_nxt = in_valid ? MC_RUN : MC_IDLE;
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign busy     = (state == MC_RUN) || (state == MC_DRAIN);
  assign out_data = res_q;
  assign mdu_a    = op_a;
  assign mdu_b    = op_b;
  assign mdu_set  = op_set;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= MC_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_set <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= in_a;
        op_b   <= in_b;
        op_set <= in_set;
      end
      if (capture) res_q <= mdu_o;
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// tb/tb_ysyx_24080006_mdu_ctrl.sv - scoreboard bench for the MDU issue/retire controller
module tb_ysyx_24080006_mdu_ctrl;
  import ysyx_24080006_pkg::*;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_data, mdu_a, mdu_b, mdu_o;
  mdu_set_t    in_set, mdu_set;
  logic        mdu_valid, mdu_ready, adder_sel_mdu, busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic        rnd_en = 1'b0;
  logic        dir_flush = 1'b0;
  logic        dir_out_ready = 1'b1;
  int          fixed_lat = 0;

  ysyx_24080006_mdu_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_set(in_set), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_set(mdu_set), .mdu_valid(mdu_valid),
    .mdu_o(mdu_o), .mdu_ready(mdu_ready), .adder_sel_mdu(adder_sel_mdu), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of each op, RISC-V M semantics.
  function automatic logic [31:0] ref_mdu(input mdu_op_t op, input logic sa, input logic sb,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    case (op)
      ALU_MULL: return p[31:0];
      ALU_MULH: return p[63:32];
      ALU_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        if (sa) return 32'($signed(a) / $signed(b));
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        if (sa) return 32'($signed(a) % $signed(b));
        return a % b;
      end
    endcase
  endfunction

  // Behavioural MDU: busy for a number of enabled cycles, then a one-cycle finish pulse.
  initial begin
    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_res;
    m_busy = 1'b0; m_cnt = 0; m_res = '0;
    mdu_ready = 1'b0; mdu_o = '0;
    forever begin
      @(posedge clock); #1;
      mdu_ready = 1'b0;
      mdu_o     = $urandom;
      if (reset) begin
        m_busy = 1'b0;
      end else if (mdu_valid) begin
        if (!m_busy) begin
          m_busy = 1'b1;
          m_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
          m_res  = ref_mdu(mdu_set.op, mdu_set.signed_a, mdu_set.signed_b, mdu_a, mdu_b);
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            mdu_ready = 1'b1;
            mdu_o     = m_res;
            m_busy    = 1'b0;
          end
        end
      end
    end
  end

  // Downstream/redirect driver: random in the soak phase, directed values otherwise.
  initial begin
    out_ready = 1'b1; flush = 1'b0;
    forever begin
      @(posedge clock); #2;
      if (rnd_en) begin
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 24) == 0);
      end else begin
        out_ready = dir_out_ready;
        flush     = dir_flush;
      end
    end
  end

  // Monitor: pops the scoreboard on each delivered result and checks protocol rules.
  initial begin
    logic        prev_rdy, exp_hold, prev_stall, prev_busy;
    logic [31:0] prev_data, prev_a, prev_b;
    mdu_set_t    prev_set;
    prev_rdy = 0; exp_hold = 0; prev_stall = 0; prev_busy = 0;
    prev_data = '0; prev_a = '0; prev_b = '0; prev_set = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        q.delete();
        prev_rdy = 0; exp_hold = 0; prev_stall = 0; prev_busy = 0;
      end else begin
        if (flush) begin
          chk1("in_ready_under_flush", in_ready, 1'b0);
          q.delete();
        end
        chk1("busy_vs_mdu_valid", busy, mdu_valid);
        chk1("adder_sel_vs_mdu_valid", adder_sel_mdu, mdu_valid);
        if (prev_rdy) chk1("mdu_valid_after_ready", mdu_valid, 1'b0);
        if (mdu_ready) chk1("adder_sel_at_ready", adder_sel_mdu, 1'b1);
        if (exp_hold) chk1("out_valid_after_ready", out_valid, 1'b1);
        if (prev_stall) chk32("out_data_stable", out_data, prev_data);
        if (prev_busy && busy) begin
          chk32("mdu_a_stable", mdu_a, prev_a);
          chk32("mdu_b_stable", mdu_b, prev_b);
          chk32("mdu_set_stable", 32'(mdu_set), 32'(prev_set));
        end
        if (out_valid && !out_ready) chk1("in_ready_while_stalled", in_ready, 1'b0);
        if (out_valid && !flush) begin
          chk1("out_has_pending_op", q.size() > 0, 1'b1);
          if (out_ready && q.size() > 0) chk32("result", out_data, q.pop_front());
        end
        prev_rdy   = mdu_ready;
        exp_hold   = mdu_ready && !flush && (q.size() > 0);
        prev_stall = out_valid && !out_ready && !flush;
        prev_busy  = busy;
        prev_data  = out_data;
        prev_a     = mdu_a;
        prev_b     = mdu_b;
        prev_set   = mdu_set;
      end
    end
  end

  task automatic issue(input mdu_op_t op, input logic sa, input logic sb,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int k;
    in_valid = 1'b1; in_a = a; in_b = b;
    in_set = '{op: op, signed_a: sa, signed_b: sb};
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (in_ready) break;
      @(posedge clock); #1;
    end
    if (k == 200) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: got no accept want accept");
    end else begin
      q.push_back(exp);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clock);
      if (q.size() == 0 && !busy && !out_valid) break;
    end
    if (k == 300) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got pending=%0d want 0", q.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_mdu_valid"}, mdu_valid, 1'b0);
    chk1({tag, "_adder_sel"}, adder_sel_mdu, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk32({tag, "_out_data"}, out_data, 32'd0);
    chk32({tag, "_mdu_a"}, mdu_a, 32'd0);
    chk32({tag, "_mdu_b"}, mdu_b, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_set = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed ops from the plan, with constant expectations.
    fixed_lat = 3; issue(ALU_MULL, 1'b0, 1'b0, 32'd7, 32'd6, 32'd42); wait_idle();
    fixed_lat = 2; issue(ALU_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF); wait_idle();
    fixed_lat = 5; issue(ALU_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); wait_idle();
    fixed_lat = 1; issue(ALU_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); wait_idle();
    fixed_lat = 4; issue(ALU_DIV, 1'b1, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF); wait_idle();
    fixed_lat = 4; issue(ALU_REM, 1'b1, 1'b1, 32'd5, 32'd0, 32'd5); wait_idle();

    // Flush two cycles into a long DIV: the op drains and produces nothing.
    fixed_lat = 8; issue(ALU_DIV, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
    @(posedge clock); #1;
    dir_flush = 1'b1;
    @(negedge clock);
    chk1("flush_busy", busy, 1'b1);
    @(posedge clock); #1;
    dir_flush = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      chk1("drain_busy", busy, 1'b1);
      chk1("drain_in_ready", in_ready, 1'b0);
      chk1("drain_out_valid", out_valid, 1'b0);
      if (mdu_ready) break;
      @(posedge clock); #1;
    end
    if (k == 20) begin n_cmp++; n_err++; $display("FAIL drain_timeout: got no finish want finish"); end
    @(posedge clock); #1;
    @(negedge clock);
    chk1("post_drain_busy", busy, 1'b0);
    chk1("post_drain_out_valid", out_valid, 1'b0);
    @(posedge clock); #1;
    fixed_lat = 2; issue(ALU_MULL, 1'b0, 1'b0, 32'd3, 32'd3, 32'd9); wait_idle();

    // Downstream stall for five cycles with a waiting op, then release.
    dir_out_ready = 1'b0;
    fixed_lat = 2; issue(ALU_MULL, 1'b0, 1'b0, 32'd11, 32'd13, 32'd143);
    for (k = 0; k < 30; k++) begin
      @(negedge clock);
      if (out_valid) break;
      @(posedge clock); #1;
    end
    if (k == 30) begin n_cmp++; n_err++; $display("FAIL hold_timeout: got no out_valid want out_valid"); end
    @(posedge clock); #1;
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
    in_set = '{op: ALU_MULH, signed_a: 1'b0, signed_b: 1'b0};
    repeat (5) begin
      @(negedge clock);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk1("stall_out_valid", out_valid, 1'b1);
      @(posedge clock); #1;
    end
    dir_out_ready = 1'b1;
    @(negedge clock);
    chk1("release_accept", in_ready, 1'b1);
    q.push_back(32'hFFFF_FFFE);
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset while the MDU is running.
    fixed_lat = 10; issue(ALU_DIV, 1'b0, 1'b0, 32'd1000, 32'd3, 32'd333);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("midrun_reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Randomised soak with random stalls and redirects.
    fixed_lat = 0;
    rnd_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      mdu_op_t     op;
      logic        sa, sb;
      logic [31:0] a, b;
      logic [31:0] pool [5];
      pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
      pool[4] = $urandom;
      op = mdu_op_t'($urandom_range(0, 3));
      sa = 1'($urandom_range(0, 1));
      sb = (op == ALU_DIV || op == ALU_REM) ? sa : 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      issue(op, sa, sb, a, b, ref_mdu(op, sa, sb, a, b));
    end
    rnd_en = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
